// File: rtl/mem_bus_responder.sv
// Memory-side responder: accepts one load/store at a time over valid/ready and
// models a fixed access latency on a word array with byte/half/word lanes.
module mem_bus_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Request fields seen on the edge entering RESP: straight from the inputs
    // when that edge is the accept edge itself (LATENCY = 0), latched otherwise.
    logic              cur_wr;
    logic [1:0]        cur_size;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_err;
    logic [3:0]        cur_be;
    logic [DATA_W-1:0] cur_wsh;
    logic [DATA_W-1:0] cur_rsh;
    logic [DATA_W-1:0] cur_rdata;
    logic              enter_resp;
    logic              mem_we;

    always_comb begin
        if (state_q == IDLE) begin
            cur_wr    = req_write;
            cur_size  = req_size;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_wr    = wr_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        cur_idx = cur_addr[IDX_W+1:2];
        cur_err = (cur_size == 2'b11)
               || (cur_size == 2'b01 && cur_addr[0])
               || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
               || (cur_addr[31:2] >= 30'(DEPTH_WORDS));

        case (cur_size)
            2'b00:   cur_be = 4'b0001 << cur_addr[1:0];
            2'b01:   cur_be = 4'b0011 << {cur_addr[1], 1'b0};
            2'b10:   cur_be = 4'b1111;
            default: cur_be = 4'b0000;
        endcase

        // Legal accesses are naturally aligned, so a byte-offset shift serves all sizes.
        cur_wsh = cur_wdata << {cur_addr[1:0], 3'b000};
        cur_rsh = mem[cur_idx] >> {cur_addr[1:0], 3'b000};

        case (cur_size)
            2'b00:   cur_rdata = cur_rsh & 32'h0000_00ff;
            2'b01:   cur_rdata = cur_rsh & 32'h0000_ffff;
            default: cur_rdata = cur_rsh;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_wr) ? '0 : cur_rdata;
        end
        // Gating on reset drops any store whose RESP-entry edge coincides with reset.
        mem_we = enter_resp && cur_wr && !cur_err && !reset;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real register behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset; clearing it would turn a RAM into
    // thousands of flops, and its contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_wsh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares data, error flag and arrival cycle.
module tb_mem_bus_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        r0_valid, r0_ready, r0_write;
    logic [1:0]  r0_size;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_resp_valid, r0_resp_err;
    logic [31:0] r0_resp_rdata;

    always #5 clk = ~clk;

    mem_bus_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_bus_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_write(r0_write),
        .req_size(r0_size), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .resp_valid(r0_resp_valid), .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err)
    );

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rdata"}, 64'(resp_rdata), 64'(mon_e.rdata));
                check({mon_e.name, "_err"},   64'(resp_err),   64'(mon_e.err));
                check({mon_e.name, "_cycle"}, 64'(cyc),        64'(mon_e.cyc));
            end
        end
    end

    task automatic push_exp(input string name, input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        e.name  = name;
        e.err   = e_err;
        e.rdata = e_rd;
        e.cyc   = cyc + 1 + LAT;  // called at the negedge before the accept edge
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            g++;
            @(negedge clk);
        end
        check("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd);
        int busy = 0;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = ad;
        req_wdata = wd;
        push_exp(name, e_err, e_rd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hffff_fffc;
        req_wdata = 32'h0bad_0bad;
        while (!req_ready && busy < 50) begin
            busy++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(busy), 64'(LAT + 1));
    endtask

    task automatic r0_req(input string name, input logic wr, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] e_rd);
        @(negedge clk);
        r0_valid = 1'b1;
        r0_write = wr;
        r0_size  = sz;
        r0_addr  = ad;
        r0_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        check({name, "_valid"}, 64'(r0_resp_valid), 64'd1);
        check({name, "_rdata"}, 64'(r0_resp_rdata), 64'(e_rd));
        check({name, "_err"},   64'(r0_resp_err),   64'd0);
        @(negedge clk);
        check({name, "_pulse_end"}, 64'(r0_resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    logic [31:0] hs_addr [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
    logic [1:0]  hs_size [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic [31:0] hs_data [4] = '{32'h5AADBEEF, 32'h000000BE, 32'h00005AAD, 32'h0000005A};

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_addr = 32'd0; req_wdata = 32'd0;
        r0_valid = 1'b0; r0_write = 1'b0; r0_size = 2'b10;
        r0_addr = 32'd0; r0_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        reset = 1'b0;

        // Word round trip, then lane handling.
        do_req("st_w10",  1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req("ld_w10",  1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        do_req("st_b13",  1'b1, 2'b00, 32'h13, 32'h0000005A, 1'b0, 32'h0);
        do_req("ld_w10b", 1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 32'h5AADBEEF);
        do_req("ld_h12",  1'b0, 2'b01, 32'h12, 32'h0,        1'b0, 32'h00005AAD);
        do_req("ld_b11",  1'b0, 2'b00, 32'h11, 32'h0,        1'b0, 32'h000000BE);

        // Error cases.
        do_req("ld_w12_mis", 1'b0, 2'b10, 32'h12,  32'h0,    1'b1, 32'h0);
        do_req("st_h11_mis", 1'b1, 2'b01, 32'h11,  32'hFFFF, 1'b1, 32'h0);
        do_req("ld_w10_chk", 1'b0, 2'b10, 32'h10,  32'h0,    1'b0, 32'h5AADBEEF);
        do_req("ld_oor",     1'b0, 2'b10, 32'h400, 32'h0,    1'b1, 32'h0);
        do_req("ld_sz11",    1'b0, 2'b11, 32'h10,  32'h0,    1'b1, 32'h0);
        do_req("st_oor",     1'b1, 2'b10, 32'h410, 32'h1,    1'b1, 32'h0);
        do_req("st_w20",     1'b1, 2'b10, 32'h20,  32'h0,    1'b0, 32'h0);

        // Continuous req_valid with a changing address every cycle.
        wait_ready();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            req_valid = 1'b1;
            req_write = 1'b0;
            req_size  = hs_size[i % 4];
            req_addr  = hs_addr[i % 4];
            if (req_ready) push_exp($sformatf("hs%0d", i), 1'b0, hs_data[i % 4]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready();
        repeat (LAT + 2) @(negedge clk);
        check("hs_drained", 64'(sb.size()), 64'd0);

        // Reset during WAIT drops the store.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_ready_low", 64'(req_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("midrst_ready",      64'(req_ready),  64'd1);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        do_req("ld_w20", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'h0);

        // Asynchronous reset while the response pulse is up.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #2;
        check("resp_up_before_rst", 64'(resp_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_ready", 64'(req_ready),  64'd1);
        @(negedge clk);
        reset = 1'b0;
        do_req("ld_w10_after_rst", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'h5AADBEEF);

        // Zero-latency instance: response in the cycle right after accept.
        r0_req("l0_st_w08", 1'b1, 2'b10, 32'h08, 32'hCAFEF00D, 32'h0);
        r0_req("l0_ld_w08", 1'b0, 2'b10, 32'h08, 32'h0,        32'hCAFEF00D);
        r0_req("l0_ld_b09", 1'b0, 2'b00, 32'h09, 32'h0,        32'h000000F0);

        repeat (LAT + 3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the multicycle control FSM's read/write requests (instruction fetch, MDR load, store).
- Accepts one request at a time over a valid/ready handshake.
- Models a fixed access latency, performs byte/half/word lane handling on an internal word-addressed array, and returns a single-cycle response carrying read data or an error flag.
- Sits between the control/datapath and the memory array; replaces direct combinational memory access.

Parameters:
- DATA_W, 32, data width in bits; fixed at 32, not a supported override.
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load data, zero-extended, right-aligned; 0 for stores and errors
- resp_err  output  1  valid only while resp_valid is high

Behaviour:
- Reset is asynchronous and active-high on clk. Reset values:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - wait counter = 0
  - Array contents are not cleared; they are undefined until written.
- FSM states and transitions:
  - IDLE: req_ready = 1. When req_valid is high at a clk edge, latch write, size, addr and wdata.
    - LATENCY = 0 → go to RESP.
    - Otherwise → go to WAIT with counter = LATENCY-1.
  - WAIT: req_ready = 0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: req_ready = 0. resp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency: first resp_valid cycle = acceptance edge + LATENCY + 1 cycles. With LATENCY = 2, resp_valid is high in the 3rd cycle after the accept edge.
- Request rules:
  - Requests are not queued.
  - req_valid is ignored while req_ready = 0, and that ignored request is not latched.
  - Back-to-back requests are possible: the next accept occurs in the IDLE cycle after RESP (minimum 2 + LATENCY cycles per transaction).
- No response backpressure: the requester must sample resp_valid in that cycle.
- Error conditions, each setting resp_err = 1:
  - Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
  - req_size = 11.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - On any error: no array write, resp_rdata = 0, and the response still follows full latency.
- Word index and lanes:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Lanes are little-endian: byte at addr[1:0] = k occupies bits [8k+7:8k]; half at addr[1] = h occupies bits [16h+15:16h].
- Stores:
  - The array is written on the clock edge that enters RESP.
  - Only the selected lanes are modified; other bytes are preserved.
- Loads:
  - The array is read on the edge entering RESP, so a load sees all previously completed stores.
  - Data is shifted down to bit 0 and zero-extended; sign extension is the datapath's job.
- Reset asserted mid-transaction (WAIT or RESP):
  - Immediately returns to IDLE; any in-flight store is dropped (the array is not written).
  - resp_valid does not fire.
- Simultaneous req_valid and reset: reset wins and nothing is latched.
- Changes to req_* inputs after acceptance have no effect on the transaction in flight.

Test Plan:
- Word round trip (LATENCY = 2): store word 0xDEADBEEF at 0x10, then load word at 0x10 → resp_valid exactly 3 cycles after each accept; load returns resp_rdata = 0xDEADBEEF, resp_err = 0; req_ready low for 3 cycles per transaction.
- Byte and half lanes: after the word above, store byte 0x5A at 0x13 and load word 0x10 → 0x5AADBEEF. Then load half at 0x12 → 0x00005AAD, and load byte at 0x11 → 0x000000BE.
- Errors:
  - Load word at 0x12 → resp_err = 1, resp_rdata = 0.
  - Store half at 0x11 → resp_err = 1, and memory at word 0x10 is unchanged.
  - Load at word index 256 (0x400) → resp_err = 1.
  - size = 11 → resp_err = 1.
- Handshake:
  - Hold req_valid high continuously with changing addresses → only the requests sampled while req_ready = 1 are serviced, each producing exactly one resp_valid pulse.
  - LATENCY = 0 build → response appears 1 cycle after accept.
- Reset mid-operation: accept a store of 0x12345678 to 0x20, assert reset during WAIT → no resp_valid, req_ready = 1 immediately. Prior contents of 0x20 (pre-written 0x0) are read back unchanged afterwards.
- Asynchronous reset: assert reset between clock edges while in RESP → resp_valid drops to 0 before the next edge.
